// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Byte/halfword/word load-store engine in front of a word-wide
//             data memory with combinational read and falling-edge write.
//             Sub-word stores are done as read-modify-write (ACCESS reads
//             the old word, MERGE writes it back with one lane replaced).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock            in   1   single clock, rising-edge state updates
//    reset            in   1   synchronous active-high reset
//    req_valid        in   1   request present
//    req_ready        out  1   request accepted when high with req_valid
//    req_write        in   1   1 = store, 0 = load
//    req_size         in   2   00 byte, 01 halfword, 10 word, 11 illegal
//    req_unsigned     in   1   zero-extend (1) / sign-extend (0) sub-word loads
//    req_address      in   32  byte address
//    req_store_data   in   32  store data (low byte/halfword for sub-word)
//    resp_valid       out  1   one-cycle completion pulse
//    resp_error       out  1   request was erroneous (valid with resp_valid)
//    resp_load_data   out  32  extended load data, 0 for stores/errors
//    mem_address      out  30  word address to the data memory
//    mem_write_enable out  1   memory write strobe (memory writes on negedge)
//    mem_write_input  out  32  memory write data
//    mem_read_result  in   32  combinational memory read data
// ============================================================================
module load_store_unit #(
  parameter int MEM_DEPTH = 2048
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_address,
  input  logic [31:0] req_store_data,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_load_data,
  output logic [29:0] mem_address,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_input,
  input  logic [31:0] mem_read_result
);

  localparam logic [31:0] c_DEPTH = 32'(MEM_DEPTH);

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Latched request
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;

  // Old memory word for read-modify-write, and the response data register
  logic [31:0] r_old;
  logic [31:0] r_load_data;

  logic        w_accept;
  logic        w_req_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;
  logic [31:0] w_merged;

  // --------------------------------------------------------------------------
  // Request classification (on the live request, before latching)
  // --------------------------------------------------------------------------
  always_comb begin
    w_req_err = 1'b0;
    case (req_size)
      c_SIZE_HALF: w_req_err = req_address[0];
      c_SIZE_WORD: w_req_err = (req_address[1:0] != 2'b00);
      c_SIZE_BYTE: w_req_err = 1'b0;
      default:     w_req_err = 1'b1;
    endcase
    if ({2'b00, req_address[31:2]} >= c_DEPTH) begin
      w_req_err = 1'b1;
    end
  end

  // req_ready is forced low during reset so no request can slip in while
  // the block is being cleared.
  assign req_ready = (r_state == IDLE) && !reset;
  assign w_accept  = req_valid && req_ready;

  // --------------------------------------------------------------------------
  // Little-endian lane select and extension of the read word
  // --------------------------------------------------------------------------
  always_comb begin
    w_byte     = mem_read_result[{r_addr[1:0], 3'b000} +: 8];
    w_half     = mem_read_result[{r_addr[1], 4'b0000} +: 16];
    w_load_ext = mem_read_result;
    case (r_size)
      c_SIZE_BYTE: w_load_ext = r_unsigned ? {24'h000000, w_byte}
                                           : {{24{w_byte[7]}}, w_byte};
      c_SIZE_HALF: w_load_ext = r_unsigned ? {16'h0000, w_half}
                                           : {{16{w_half[15]}}, w_half};
      default:     w_load_ext = mem_read_result;
    endcase
  end

  // Old word with only the addressed lane replaced by the store data
  always_comb begin
    w_merged = r_old;
    if (r_size == c_SIZE_BYTE) begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and memory-side outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state     = r_state;
    mem_write_enable = 1'b0;
    mem_write_input  = 32'h0000_0000;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = w_req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        // Errors never reach ACCESS, so only legal operations land here.
        if (r_write && (r_size == c_SIZE_WORD)) begin
          mem_write_enable = 1'b1;
          mem_write_input  = r_wdata;
          w_next_state     = RESP;
        end else if (r_write) begin
          w_next_state = MERGE;
        end else begin
          w_next_state = RESP;
        end
      end
      MERGE: begin
        mem_write_enable = 1'b1;
        mem_write_input  = w_merged;
        w_next_state     = RESP;
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
    // A reset arriving mid-operation must abort without touching memory.
    if (reset) begin
      mem_write_enable = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Request latch and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_write     <= 1'b0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_addr      <= 32'h0000_0000;
      r_wdata     <= 32'h0000_0000;
      r_err       <= 1'b0;
      r_old       <= 32'h0000_0000;
      r_load_data <= 32'h0000_0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write     <= req_write;
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_addr      <= req_address;
            r_wdata     <= req_store_data;
            r_err       <= w_req_err;
            r_old       <= 32'h0000_0000;
            // Stores and errors report zero load data.
            r_load_data <= 32'h0000_0000;
          end
        end
        ACCESS: begin
          if (!r_write) begin
            r_load_data <= w_load_ext;
          end else if (r_size != c_SIZE_WORD) begin
            r_old <= mem_read_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_address    = r_addr[31:2];
  assign resp_valid     = (r_state == RESP);
  assign resp_error     = r_err;
  assign resp_load_data = r_load_data;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Self-checking bench for load_store_unit. Directed requests push
//             their expected response into a queue; a monitor on the falling
//             edge pops and compares data, error, latency and write activity.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_address;
  logic [31:0] req_store_data;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_load_data;
  logic [29:0] mem_address;
  logic        mem_write_enable;
  logic [31:0] mem_write_input;
  logic [31:0] mem_read_result;

  always #5 clock = ~clock;

  load_store_unit #(.MEM_DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_address      (req_address),
    .req_store_data   (req_store_data),
    .resp_valid       (resp_valid),
    .resp_error       (resp_error),
    .resp_load_data   (resp_load_data),
    .mem_address      (mem_address),
    .mem_write_enable (mem_write_enable),
    .mem_write_input  (mem_write_input),
    .mem_read_result  (mem_read_result)
  );

  // Data memory: combinational read, falling-edge write
  logic [31:0] mem [0:DEPTH-1];

  always_comb begin
    mem_read_result = 32'h0;
    if (mem_address < 30'(DEPTH)) mem_read_result = mem[mem_address[AW-1:0]];
  end

  always @(negedge clock) begin
    if (mem_write_enable && (mem_address < 30'(DEPTH)))
      mem[mem_address[AW-1:0]] <= mem_write_input;
  end

  // Scoreboard
  typedef struct {
    logic        err;
    logic [31:0] data;
    int          lat;
    int          writes;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   wr_count = 0;
  int   wr_cycle = 0;
  int   wr_total = 0;
  int   n_acc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clock) begin
    if (reset) begin
      acc_q.delete();
      wr_count = 0;
      check("wen_during_reset", {31'b0, mem_write_enable}, 32'h0);
    end else begin
      if (mem_write_enable) begin
        wr_count++;
        wr_total++;
        wr_cycle = cyc;
      end
      if (resp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("resp_error", {31'b0, resp_error}, {31'b0, e.err});
          check("resp_load_data", resp_load_data, e.data);
          check("latency", 32'(cyc - a), 32'(e.lat));
          check("write_count", 32'(wr_count), 32'(e.writes));
          if (e.writes == 1) check("write_cycle", 32'(wr_cycle - a), 32'(e.lat - 1));
        end
      end
      if (req_valid && req_ready) begin
        check("accept_while_busy", 32'(acc_q.size()), 32'h0);
        acc_q.push_back(cyc);
        wr_count = 0;
        n_acc++;
      end
    end
  end

  // Stimulus helpers
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_data,
                       input int e_lat, input int e_wr,
                       input bit expect_resp, input bit hold);
    exp_t e;
    int   t;
    req_write      = w;
    req_size       = sz;
    req_unsigned   = u;
    req_address    = a;
    req_store_data = d;
    req_valid      = 1'b1;
    if (expect_resp) begin
      e.err = e_err; e.data = e_data; e.lat = e_lat; e.writes = e_wr;
      exp_q.push_back(e);
    end
    t = 0;
    while (!req_ready && t < 20) begin
      @(posedge clock); #1;
      t++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got no req_ready expected accept within 20 cycles");
      req_valid = 1'b0;
    end else begin
      @(posedge clock); #1;
      if (!hold) req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 30) begin
      @(posedge clock); #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wt;
    int na;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_address = 32'h0; req_store_data = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    check("ready_in_reset", {31'b0, req_ready}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_error", {31'b0, resp_error}, 32'h0);
    check("rst_load_data", resp_load_data, 32'h0);
    check("rst_mem_address", {2'b0, mem_address}, 32'h0);
    check("rst_wen", {31'b0, mem_write_enable}, 32'h0);
    @(posedge clock); #1;

    // Word store then unsigned byte load
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 1'b0, 32'h0, 2, 1, 1'b1, 1'b0);
    drain();
    check("mem_after_word_store", mem[4], 32'h12345678);
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, 32'h00000056, 2, 0, 1'b1, 1'b0);
    drain();

    // Halfword loads, signed and unsigned, over 0x80FF0000
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF0000, 1'b0, 32'h0, 2, 1, 1'b1, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF80FF, 2, 0, 1'b1, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'h000080FF, 2, 0, 1'b1, 1'b0);
    drain();

    // Sub-word stores (read-modify-write)
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h0, 2, 1, 1'b1, 1'b0);
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'hCDEF01AB, 1'b0, 32'h0, 3, 1, 1'b1, 1'b0);
    drain();
    check("mem_after_byte_store", mem[4], 32'hAB223344);
    issue(1'b1, 2'b01, 1'b0, 32'h10, 32'h1234BEEF, 1'b0, 32'h0, 3, 1, 1'b1, 1'b0);
    drain();
    check("mem_after_half_store", mem[4], 32'hAB22BEEF);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFFFFAB, 2, 0, 1'b1, 1'b0);
    drain();

    // Erroneous requests
    wt = wr_total;
    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1, 32'h0, 1, 0, 1'b1, 1'b0);
    issue(1'b1, 2'b01, 1'b0, 32'h01, 32'h0000FFFF, 1'b1, 32'h0, 1, 0, 1'b1, 1'b0);
    issue(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0, 1, 0, 1'b1, 1'b0);
    issue(1'b1, 2'b10, 1'b0, 32'(4 * DEPTH), 32'hDEADBEEF, 1'b1, 32'h0, 1, 0, 1'b1, 1'b0);
    drain();
    check("no_write_on_errors", 32'(wr_total - wt), 32'h0);
    check("mem_after_errors", mem[4], 32'hAB22BEEF);

    // Reset during MERGE aborts the store
    wt = wr_total;
    issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h00000055, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);
    @(posedge clock); #1;              // now in MERGE
    reset = 1'b1;
    @(negedge clock);
    check("merge_reset_ready", {31'b0, req_ready}, 32'h0);
    check("merge_reset_wen", {31'b0, mem_write_enable}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_ready", {31'b0, req_ready}, 32'h1);
    check("post_reset_resp_valid", {31'b0, resp_valid}, 32'h0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("abort_no_write", 32'(wr_total - wt), 32'h0);
    check("mem_after_abort", mem[4], 32'hAB22BEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hAB22BEEF, 2, 0, 1'b1, 1'b0);
    drain();

    // req_valid held high across back-to-back requests
    na = n_acc;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hAB22BEEF, 2, 0, 1'b1, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0, 32'h00000022, 2, 0, 1'b1, 1'b1);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0000BEEF, 2, 0, 1'b1, 1'b1);
    issue(1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, 1'b1, 1'b0);
    drain();
    check("b2b_accepts", 32'(n_acc - na), 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
